// File: rtl/serial_rx7.sv
// serial_rx7: receiver for the single-clock 7-bit serial link.
// Frame: start bit (0), DATA_BITS data bits LSB first, then an even-parity bit.
// There is no stop bit.
// Each recovered word is presented with a one-cycle valid strobe.
// A parity mismatch gives a one-cycle parity_err strobe and bumps a saturating error counter.
// Optional build macro RX_PARITY_DROP_EN: when defined, a bad-parity frame raises
// only parity_err. data_out is left untouched and valid is not raised.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | line idle; a 0 on serial_in is a start bit
// DATA   | sampling data bit idx into the shift register
// PARITY | sampling parity bit, finalizing the frame
module serial_rx7 #(
    parameter int DATA_BITS = 7,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 finalize;
    logic                 parity_bad;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic and frame-completion decode
    always_comb begin
        state_nxt  = state;
        finalize   = 1'b0;
        parity_bad = 1'b0;
        case (state)
            S_IDLE: begin
                if (!serial_in) state_nxt = S_DATA;
            end
            S_DATA: begin
                if (idx == LAST_IDX) state_nxt = S_PARITY;
            end
            S_PARITY: begin
                finalize   = 1'b1;
                parity_bad = serial_in ^ (^shreg);
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bit index and shift register; the index is cleared on the start bit
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx   <= '0;
            shreg <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!serial_in) idx <= '0;
                end
                S_DATA: begin
                    shreg[idx] <= serial_in;
                    idx        <= idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Frame outputs: one-cycle strobes, held word, saturating error count
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            err_cnt    <= '0;
        end else begin
            valid      <= 1'b0;
            parity_err <= 1'b0;
            if (finalize) begin
                if (!parity_bad) begin
                    data_out <= shreg;
                    valid    <= 1'b1;
                end else begin
                    parity_err <= 1'b1;
                    if (!(&err_cnt)) err_cnt <= err_cnt + ERR_CNT_W'(1);
`ifdef RX_PARITY_DROP_EN
                    // Bad words are discarded; the last good word stays visible.
`else
                    data_out <= shreg;
                    valid    <= 1'b1;
`endif
                end
            end
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_serial_rx7.sv
// Testbench for serial_rx7.
// Frames are driven on the falling edge. For each frame the expected output
// event is queued: the edge number, the word, the strobes and the error count.
// A monitor process compares these against the DUT outputs on falling edges.
module tb_serial_rx7;

    logic       clk;
    logic       rstn;
    logic       serial_in;
    logic [6:0] data_out;
    logic       valid;
    logic       parity_err;
    logic       busy;
    logic [7:0] err_cnt;

    serial_rx7 dut (
        .clk       (clk),
        .rstn      (rstn),
        .serial_in (serial_in),
        .data_out  (data_out),
        .valid     (valid),
        .parity_err(parity_err),
        .busy      (busy),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [6:0] data;
        logic       vld;
        logic       perr;
        logic [7:0] err;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    logic [6:0] model_data = '0;
    int         model_err = 0;

    always @(posedge clk) cyc++;

    // Monitor: every output event must match the oldest expectation, on time
    always @(negedge clk) begin
        if (rstn) begin
            if (valid || parity_err) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stray_out: cycle %0d valid=%0b parity_err=%0b data=%h, no frame outstanding",
                             cyc, valid, parity_err, data_out);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (cyc != e.due || valid != e.vld || parity_err != e.perr ||
                        data_out != e.data || err_cnt != e.err) begin
                        n_fail++;
                        $display("FAIL frame_out: got cyc=%0d valid=%0b perr=%0b data=%h err=%0d, want cyc=%0d valid=%0b perr=%0b data=%h err=%0d",
                                 cyc, valid, parity_err, data_out, err_cnt,
                                 e.due, e.vld, e.perr, e.data, e.err);
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                n_tests++;
                n_fail++;
                $display("FAIL missing_out: no strobe at cycle %0d, want valid=%0b perr=%0b data=%h",
                         cyc, e.vld, e.perr, e.data);
            end
        end
    end

    task automatic check_busy(input logic want, input string name);
        n_tests++;
        if (busy !== want) begin
            n_fail++;
            $display("FAIL %s: busy=%0b want %0b at cycle %0d", name, busy, want, cyc);
        end
    endtask

    // Sends one full frame. bad=1 inverts the parity bit.
    task automatic send_frame(input logic [6:0] d, input logic bad);
        exp_t e;
        logic par;
        int   start_cyc;
        par = 1'b0;
        for (int i = 0; i < 7; i++) par = par ^ d[i];
        @(negedge clk);
        check_busy(1'b0, "busy_before_start");
        serial_in = 1'b0;
        start_cyc = cyc;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check_busy(1'b1, "busy_data");
            serial_in = d[i];
        end
        @(negedge clk);
        check_busy(1'b1, "busy_parity");
        serial_in = par ^ bad;
        // Expected result from the frame rules alone
        if (bad) model_err = (model_err >= 255) ? 255 : model_err + 1;
`ifdef RX_PARITY_DROP_EN
        if (!bad) model_data = d;
        e.vld = !bad;
`else
        model_data = d;
        e.vld = 1'b1;
`endif
        e.due  = start_cyc + 9;
        e.data = model_data;
        e.perr = bad;
        e.err  = 8'(model_err);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            serial_in = 1'b1;
        end
    endtask

    initial begin
        logic idle_bad;
        logic rst_bad;
        int   wait_cyc;
        rstn = 1'b0;
        serial_in = 1'b1;
        #23;
        n_tests++;
        if (data_out !== 7'h0 || valid !== 1'b0 || parity_err !== 1'b0 ||
            busy !== 1'b0 || err_cnt !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_vals: data=%h valid=%0b perr=%0b busy=%0b err=%0d, want all 0",
                     data_out, valid, parity_err, busy, err_cnt);
        end
        @(negedge clk);
        rstn = 1'b1;

        // Idle line held high
        idle_bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy || valid || parity_err || data_out != 7'h0) idle_bad = 1'b1;
        end
        n_tests++;
        if (idle_bad) begin
            n_fail++;
            $display("FAIL idle_line: activity seen, busy=%0b valid=%0b data=%h, want 0", busy, valid, data_out);
        end

        send_frame(7'h55, 1'b0);
        idle(3);
        send_frame(7'h01, 1'b0);
        send_frame(7'h7F, 1'b0);
        idle(2);
        send_frame(7'h03, 1'b1);
        idle(4);

        // Randomized frames with random gaps and occasional parity faults
        for (int n = 0; n < 40; n++) begin
            send_frame(7'($urandom_range(0, 127)), ($urandom_range(0, 3) == 0));
            idle($urandom_range(0, 3));
        end

        // Continuous low line: back-to-back all-zero good frames
        for (int n = 0; n < 3; n++) send_frame(7'h00, 1'b0);
        idle(12);

        // Reset during data bit 3
        send_frame(7'h6B, 1'b0);
        idle(10);
        @(negedge clk);
        serial_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            serial_in = i[0];
        end
        #2;
        rstn = 1'b0;
        #1;
        rst_bad = (data_out !== 7'h0 || valid !== 1'b0 || parity_err !== 1'b0 ||
                   busy !== 1'b0 || err_cnt !== 8'h0);
        n_tests++;
        if (rst_bad) begin
            n_fail++;
            $display("FAIL async_reset: data=%h valid=%0b perr=%0b busy=%0b err=%0d, want all 0",
                     data_out, valid, parity_err, busy, err_cnt);
        end
        serial_in = 1'b1;
        exp_q.delete();
        model_data = '0;
        model_err = 0;
        @(negedge clk);
        rstn = 1'b1;
        idle(2);
        send_frame(7'h2A, 1'b0);
        idle(12);

        // Error counter saturation
        for (int n = 0; n < 260; n++) send_frame(7'($urandom_range(0, 127)), 1'b1);
        idle(12);
        n_tests++;
        if (err_cnt !== 8'hFF) begin
            n_fail++;
            $display("FAIL err_saturate: err_cnt=%0d want 255", err_cnt);
        end
        send_frame(7'h11, 1'b0);

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 30) begin
            @(negedge clk);
            wait_cyc++;
        end
        n_tests++;
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected frames never appeared", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
